// File: rtl/led_axi_pwm_n.sv
// led_axi_pwm_n: AXI4 slave driving NUM_LEDS outputs, static pattern or PWM.
//   s00_axi_*   : AXI4 full slave (INCR/FIXED/WRAP, one outstanding txn per dir)
//   led         : registered LED drive
// Map (word index): 0 CTRL {MODE,EN}, 1 PATTERN, 2+i BRIGHT[i]; others SLVERR.

module led_pwm_lane #(
  parameter int PWM_WIDTH = 8
) (
  input  logic [PWM_WIDTH-1:0] cnt,
  input  logic [PWM_WIDTH-1:0] bright,
  output logic                 on
);
  // all-ones brightness means fully on (covers the cnt == max slot too)
  assign on = (cnt < bright) || (&bright);
endmodule

module led_axi_pwm_n #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6,
  parameter int C_S_AXI_ID_WIDTH   = 1,
  parameter int NUM_LEDS           = 8,
  parameter int PWM_WIDTH          = 8
) (
  input  logic                            s00_axi_aclk,
  input  logic                            s00_axi_areset,
  input  logic [C_S_AXI_ID_WIDTH-1:0]     s00_axi_awid,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic [7:0]                      s00_axi_awlen,
  input  logic [2:0]                      s00_axi_awsize,
  input  logic [1:0]                      s00_axi_awburst,
  input  logic                            s00_axi_awvalid,
  output logic                            s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                            s00_axi_wlast,
  input  logic                            s00_axi_wvalid,
  output logic                            s00_axi_wready,
  output logic [C_S_AXI_ID_WIDTH-1:0]     s00_axi_bid,
  output logic [1:0]                      s00_axi_bresp,
  output logic                            s00_axi_bvalid,
  input  logic                            s00_axi_bready,
  input  logic [C_S_AXI_ID_WIDTH-1:0]     s00_axi_arid,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic [7:0]                      s00_axi_arlen,
  input  logic [2:0]                      s00_axi_arsize,
  input  logic [1:0]                      s00_axi_arburst,
  input  logic                            s00_axi_arvalid,
  output logic                            s00_axi_arready,
  output logic [C_S_AXI_ID_WIDTH-1:0]     s00_axi_rid,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                      s00_axi_rresp,
  output logic                            s00_axi_rlast,
  output logic                            s00_axi_rvalid,
  input  logic                            s00_axi_rready,
  output logic [NUM_LEDS-1:0]             led
);
  localparam int DW   = C_S_AXI_DATA_WIDTH;
  localparam int IW   = C_S_AXI_ADDR_WIDTH - 2;
  localparam int NMAP = 1 << IW;
  localparam logic [IW:0] NREG_W = (IW+1)'(2 + NUM_LEDS);

  typedef enum logic [1:0] {WIDLE, WDATA, WRESP} wstate_t;
  typedef enum logic       {RIDLE, RDATA}        rstate_t;

  logic                                 clk, rst;
  logic [1:0]                           ctrl;
  logic [NUM_LEDS-1:0]                  pattern;
  logic [NUM_LEDS-1:0][PWM_WIDTH-1:0]   bright;
  logic [PWM_WIDTH-1:0]                 cnt;
  logic [NUM_LEDS-1:0]                  pwm_on;
  logic [DW-1:0]                        rmap [NMAP];

  assign clk = s00_axi_aclk;
  assign rst = s00_axi_areset;

  // Burst address step on the word index. WRAP keeps the upper bits and
  // increments only the bits inside the (len+1)-word window.
  function automatic logic [IW-1:0] nxt_idx(input logic [IW-1:0] idx,
                                            input logic [7:0] len,
                                            input logic [1:0] burst);
    logic [IW-1:0] msk;
    logic          wrap_ok;
    msk     = IW'(len);
    wrap_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    if (burst == 2'b00)                 return idx;
    else if (burst == 2'b10 && wrap_ok) return (idx & ~msk) | ((idx + 1'b1) & msk);
    else                                return idx + 1'b1;
  endfunction

  function automatic logic mapped(input logic [IW-1:0] idx);
    return {1'b0, idx} < NREG_W;
  endfunction

  // Read view of the whole index space; unmapped words and bits are zero.
  always_comb begin
    for (int k = 0; k < NMAP; k++) rmap[k] = '0;
    rmap[0][1:0]          = ctrl;
    rmap[1][NUM_LEDS-1:0] = pattern;
    for (int i = 0; i < NUM_LEDS; i++) rmap[2+i][PWM_WIDTH-1:0] = bright[i];
  end

  // ---------------- write channel ----------------
  wstate_t         w_st, w_nxt;
  logic [IW-1:0]   w_idx;
  logic [7:0]      w_len, w_cnt;
  logic [1:0]      w_burst;
  logic            w_err;
  logic [DW-1:0]   wmerge;
  logic            aw_hs, w_hs, b_hs;

  assign aw_hs = s00_axi_awvalid && s00_axi_awready;
  assign w_hs  = s00_axi_wvalid  && s00_axi_wready;
  assign b_hs  = s00_axi_bvalid  && s00_axi_bready;

  always_comb begin
    w_nxt = w_st;
    case (w_st)
      WIDLE:   if (aw_hs) w_nxt = WDATA;
      WDATA:   if (w_hs && w_cnt == w_len) w_nxt = WRESP;
      WRESP:   if (b_hs) w_nxt = WIDLE;
      default: w_nxt = WIDLE;
    endcase
  end

  always_comb begin
    wmerge = rmap[w_idx];
    for (int b = 0; b < DW/8; b++)
      if (s00_axi_wstrb[b]) wmerge[8*b +: 8] = s00_axi_wdata[8*b +: 8];
  end

  // handshake outputs are registered from the next state so they read 0 in reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_st            <= WIDLE;
      s00_axi_awready <= 1'b0;
      s00_axi_wready  <= 1'b0;
      s00_axi_bvalid  <= 1'b0;
    end else begin
      w_st            <= w_nxt;
      s00_axi_awready <= (w_nxt == WIDLE);
      s00_axi_wready  <= (w_nxt == WDATA);
      s00_axi_bvalid  <= (w_nxt == WRESP);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s00_axi_bid <= '0;
      w_idx       <= '0;
      w_len       <= '0;
      w_cnt       <= '0;
      w_burst     <= '0;
      w_err       <= 1'b0;
      ctrl        <= '0;
      pattern     <= '0;
      bright      <= '0;
    end else begin
      if (aw_hs) begin
        s00_axi_bid <= s00_axi_awid;
        w_idx       <= s00_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:2];
        w_len       <= s00_axi_awlen;
        w_burst     <= s00_axi_awburst;
        w_cnt       <= '0;
        w_err       <= 1'b0;
      end
      if (w_hs) begin
        w_idx <= nxt_idx(w_idx, w_len, w_burst);
        w_cnt <= w_cnt + 8'd1;
        if (!mapped(w_idx)) w_err <= 1'b1;
        else begin
          if (w_idx == IW'(0)) ctrl    <= wmerge[1:0];
          if (w_idx == IW'(1)) pattern <= wmerge[NUM_LEDS-1:0];
          for (int i = 0; i < NUM_LEDS; i++)
            if (w_idx == IW'(2+i)) bright[i] <= wmerge[PWM_WIDTH-1:0];
        end
      end
    end
  end

  assign s00_axi_bresp = {w_err, 1'b0};

  // ---------------- read channel ----------------
  rstate_t         r_st, r_nxt;
  logic [IW-1:0]   r_idx, r_sel;
  logic [7:0]      r_len, r_cnt;
  logic [1:0]      r_burst;
  logic            ar_hs, r_hs, r_load;

  assign ar_hs  = s00_axi_arvalid && s00_axi_arready;
  assign r_hs   = s00_axi_rvalid  && s00_axi_rready;
  assign r_load = ar_hs || (r_hs && !s00_axi_rlast);
  // next beat index: first beat from AR, later beats from the burst step
  assign r_sel  = (r_st == RIDLE) ? s00_axi_araddr[C_S_AXI_ADDR_WIDTH-1:2]
                                  : nxt_idx(r_idx, r_len, r_burst);

  always_comb begin
    r_nxt = r_st;
    case (r_st)
      RIDLE:   if (ar_hs) r_nxt = RDATA;
      RDATA:   if (r_hs && s00_axi_rlast) r_nxt = RIDLE;
      default: r_nxt = RIDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_st            <= RIDLE;
      s00_axi_arready <= 1'b0;
      s00_axi_rvalid  <= 1'b0;
    end else begin
      r_st            <= r_nxt;
      s00_axi_arready <= (r_nxt == RIDLE);
      s00_axi_rvalid  <= (r_nxt == RDATA);
    end
  end

  // rdata is captured at the handshake that precedes the beat, so a write
  // landing in the same cycle is not seen (pre-write value returned).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s00_axi_rid   <= '0;
      s00_axi_rdata <= '0;
      s00_axi_rresp <= 2'b00;
      s00_axi_rlast <= 1'b0;
      r_idx         <= '0;
      r_len         <= '0;
      r_cnt         <= '0;
      r_burst       <= '0;
    end else begin
      if (ar_hs) begin
        s00_axi_rid <= s00_axi_arid;
        r_len       <= s00_axi_arlen;
        r_burst     <= s00_axi_arburst;
      end
      if (r_load) begin
        r_idx         <= r_sel;
        s00_axi_rdata <= rmap[r_sel];
        s00_axi_rresp <= mapped(r_sel) ? 2'b00 : 2'b10;
        r_cnt         <= ar_hs ? 8'd0 : r_cnt + 8'd1;
        s00_axi_rlast <= ar_hs ? (s00_axi_arlen == 8'd0) : (r_cnt + 8'd1 == r_len);
      end else if (r_hs) begin
        s00_axi_rlast <= 1'b0;
      end
    end
  end

  // ---------------- PWM / LED ----------------
  for (genvar g = 0; g < NUM_LEDS; g++) begin : g_lane
    led_pwm_lane #(.PWM_WIDTH(PWM_WIDTH)) u_lane (
      .cnt(cnt), .bright(bright[g]), .on(pwm_on[g])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      led <= '0;
    end else begin
      cnt <= cnt + 1'b1;
      led <= !ctrl[0] ? '0 : (ctrl[1] ? pwm_on : pattern);
    end
  end

  // size is fixed at one word; wlast is redundant with awlen
  logic unused_ok;
  assign unused_ok = ^{s00_axi_awsize, s00_axi_arsize, s00_axi_wlast,
                       s00_axi_awaddr[1:0], s00_axi_araddr[1:0], wmerge};
endmodule

// File: tb/tb_led_axi_pwm_n.sv
module tb_led_axi_pwm_n;
  localparam int NREG = 10;  // 2 + NUM_LEDS

  logic        clk = 1'b0, rst = 1'b1;
  logic [0:0]  awid, bid, arid, rid;
  logic [5:0]  awaddr, araddr;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [7:0]  led;

  always #5 clk = ~clk;

  led_axi_pwm_n dut (
    .s00_axi_aclk(clk), .s00_axi_areset(rst),
    .s00_axi_awid(awid), .s00_axi_awaddr(awaddr), .s00_axi_awlen(awlen),
    .s00_axi_awsize(awsize), .s00_axi_awburst(awburst),
    .s00_axi_awvalid(awvalid), .s00_axi_awready(awready),
    .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb), .s00_axi_wlast(wlast),
    .s00_axi_wvalid(wvalid), .s00_axi_wready(wready),
    .s00_axi_bid(bid), .s00_axi_bresp(bresp), .s00_axi_bvalid(bvalid), .s00_axi_bready(bready),
    .s00_axi_arid(arid), .s00_axi_araddr(araddr), .s00_axi_arlen(arlen),
    .s00_axi_arsize(arsize), .s00_axi_arburst(arburst),
    .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
    .s00_axi_rid(rid), .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rlast(rlast),
    .s00_axi_rvalid(rvalid), .s00_axi_rready(rready),
    .led(led)
  );

  int          n_tests = 0, n_fail = 0;
  logic [31:0] mreg [16];
  logic [31:0] wd [16];
  logic [3:0]  ws [16];
  logic [31:0] rd_last;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // reference: byte-address burst sequencing straight from the burst rules
  function automatic int nxt_addr(input int a, input int len, input int burst);
    int sz, base;
    if (burst == 0) return a;
    if (burst == 2 && (len == 1 || len == 3 || len == 7 || len == 15)) begin
      sz   = (len + 1) * 4;
      base = a - (a % sz);
      return base + ((a - base + 4) % sz);
    end
    return (a + 4) % 64;
  endfunction

  function automatic logic [31:0] mrd(input int idx);
    return (idx < NREG) ? mreg[idx] : 32'h0;
  endfunction

  task automatic mwrite(input int idx, input logic [31:0] d, input logic [3:0] s, inout bit err);
    if (idx >= NREG) begin err = 1; return; end
    for (int b = 0; b < 4; b++) if (s[b]) mreg[idx][8*b +: 8] = d[8*b +: 8];
    mreg[idx] &= (idx == 0) ? 32'h3 : 32'hFF;
  endtask

  task automatic wait_hi(input string tag, ref logic sig);
    int t = 0;
    while (!sig && t < 300) begin @(negedge clk); t++; end
    if (t >= 300) chk(tag, 32'(sig), 32'h1);
  endtask

  task automatic axi_write(input int addr, input int len, input int burst);
    int a = addr; bit err = 0; logic [0:0] id;
    id = 1'($urandom_range(0, 1));
    for (int i = 0; i <= len; i++) begin mwrite(a / 4, wd[i], ws[i], err); a = nxt_addr(a, len, burst); end
    awid = id; awaddr = 6'(addr); awlen = 8'(len); awburst = 2'(burst);
    awsize = 3'($urandom_range(0, 7)); awvalid = 1'b1;
    wait_hi("awready_timeout", awready);
    @(negedge clk); awvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      wdata = wd[i]; wstrb = ws[i]; wlast = (i == len); wvalid = 1'b1;
      wait_hi("wready_timeout", wready);
      @(negedge clk); wvalid = 1'b0; wlast = 1'b0;
    end
    if ($urandom_range(0, 1) == 0) @(negedge clk);
    bready = 1'b1;
    wait_hi("bvalid_timeout", bvalid);
    chk("bresp", 32'(bresp), err ? 32'h2 : 32'h0);
    chk("bid", 32'(bid), 32'(id));
    @(negedge clk); bready = 1'b0;
  endtask

  // stall=1 toggles rready every cycle and checks rdata holds while stalled
  task automatic axi_read(input int addr, input int len, input int burst, input bit stall);
    int a = addr, beat = 0, t = 0; bit held = 0; logic [31:0] hval = 0; logic [0:0] id;
    id = 1'($urandom_range(0, 1));
    arid = id; araddr = 6'(addr); arlen = 8'(len); arburst = 2'(burst);
    arsize = 3'($urandom_range(0, 7)); arvalid = 1'b1;
    wait_hi("arready_timeout", arready);
    @(negedge clk); arvalid = 1'b0;
    chk("rvalid_first", 32'(rvalid), 32'h1);
    rready = 1'b0;
    while (beat <= len && t < 500) begin
      rready = stall ? ~rready : 1'b1;
      if (rvalid) begin
        if (held) chk("rdata_stable", rdata, hval);
        if (rready) begin
          chk("rdata", rdata, mrd(a / 4));
          chk("rresp", 32'(rresp), (a / 4 < NREG) ? 32'h0 : 32'h2);
          chk("rlast", 32'(rlast), 32'(beat == len));
          chk("rid", 32'(rid), 32'(id));
          rd_last = rdata; a = nxt_addr(a, len, burst); beat++; held = 0;
        end else begin
          held = 1; hval = rdata;
        end
      end
      @(negedge clk); t++;
    end
    rready = 1'b0;
    chk("r_beats", 32'(beat), 32'(len + 1));
    chk("rvalid_end", 32'(rvalid), 32'h0);
  endtask

  initial begin
    int on0, on1, on2; bit bv_seen;
    awid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0; awvalid = 0;
    wdata = 0; wstrb = 0; wlast = 0; wvalid = 0; bready = 0;
    arid = 0; araddr = 0; arlen = 0; arsize = 0; arburst = 0; arvalid = 0; rready = 0;
    for (int k = 0; k < 16; k++) mreg[k] = 0;
    repeat (3) @(negedge clk);
    chk("rst_hs", 32'({awready, wready, bvalid, arready, rvalid}), 32'h0);
    chk("rst_resp", 32'({bresp, rresp}), 32'h0);
    chk("rst_led", 32'(led), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("awready_after_rst", 32'(awready), 32'h1);

    // static mode: CTRL=EN, PATTERN=A5
    wd[0] = 1; wd[1] = 32'hA5; wd[2] = 0; wd[3] = 0;
    for (int i = 0; i < 4; i++) ws[i] = 4'hF;
    axi_write(0, 3, 1);
    chk("led_static", 32'(led), 32'hA5);

    // PWM mode duty cycles over one full period
    wd[0] = 3; ws[0] = 4'hF; axi_write(0, 0, 1);
    wd[0] = 64; wd[1] = 255; wd[2] = 0; ws[1] = 4'hF; ws[2] = 4'hF;
    axi_write(8, 2, 1);
    repeat (2) @(negedge clk);
    on0 = 0; on1 = 0; on2 = 0;
    for (int c = 0; c < 256; c++) begin
      on0 += int'(led[0]); on1 += int'(led[1]); on2 += int'(led[2]);
      @(negedge clk);
    end
    chk("pwm_on0", 32'(on0), 32'd64);
    chk("pwm_on1", 32'(on1), 32'd256);
    chk("pwm_on2", 32'(on2), 32'd0);

    // INCR read of whole map with stalls
    axi_read(0, 9, 1, 1);

    // distinct BRIGHT[2..5], then WRAP read from index 6 (6,7,4,5)
    for (int i = 0; i < 4; i++) begin wd[i] = 32'h10 + 32'(i) * 7; ws[i] = 4'hF; end
    axi_write(16, 3, 1);
    axi_read(24, 3, 2, 0);

    // FIXED write len 3 to PATTERN leaves the last beat
    for (int i = 0; i < 4; i++) begin wd[i] = 32'(i + 1); ws[i] = 4'hF; end
    axi_write(4, 3, 0);
    axi_read(4, 0, 1, 0);
    chk("fixed_pattern", rd_last, 32'd4);

    // unmapped index 12
    wd[0] = 32'hFFFF_FFFF; ws[0] = 4'h1;
    axi_write(48, 0, 1);
    axi_read(48, 0, 1, 0);
    axi_read(0, 9, 1, 0);

    // byte lane 1 on PATTERN lands in unimplemented bits
    wd[0] = 32'h1234_5678; ws[0] = 4'h2;
    axi_write(4, 0, 1);
    axi_read(4, 0, 1, 0);
    chk("partial_strb_pattern", rd_last, 32'd4);

    // randomized bursts against the model
    for (int n = 0; n < 12; n++) begin
      int a, l, b;
      a = 4 * $urandom_range(0, 15); l = $urandom_range(0, 7); b = $urandom_range(0, 3);
      for (int i = 0; i < 16; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom_range(0, 15)); end
      axi_write(a, l, b);
      axi_read(4 * $urandom_range(0, 15), $urandom_range(0, 7), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end
    axi_read(0, 15, 1, 0);

    // reset during beat 2 of a len-7 write
    awid = 0; awaddr = 0; awlen = 7; awburst = 1; awsize = 2; awvalid = 1'b1;
    wait_hi("awready_timeout", awready);
    @(negedge clk); awvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      wdata = 32'hFF; wstrb = 4'hF; wvalid = 1'b1;
      wait_hi("wready_timeout", wready);
      @(negedge clk);
    end
    wdata = 32'h3; #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_hs", 32'({awready, wready, bvalid}), 32'h0);
    rst = 1'b0; wvalid = 1'b0; bready = 1'b1;
    @(negedge clk);
    chk("awready_after_midrst", 32'(awready), 32'h1);
    bv_seen = 0;
    for (int c = 0; c < 20; c++) begin bv_seen |= bvalid; @(negedge clk); end
    chk("bvalid_never", 32'(bv_seen), 32'h0);
    bready = 1'b0;
    for (int k = 0; k < 16; k++) mreg[k] = 0;
    chk("led_after_midrst", 32'(led), 32'h0);
    axi_read(0, 15, 1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
